// File: rtl/telemetry_rx.sv
`default_nettype none
// ============================================================================
// Module      : telemetry_rx
// Description : Receive side of the eBike telemetry link. Deserializes an
//               8N1 UART stream, frames the 8-byte packet
//               (0xAA, 0x55, batt_hi, batt_lo, curr_hi, curr_lo,
//               torque_hi, torque_lo) and presents the three 12-bit values
//               with a one-cycle packet-ready strobe.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   BAUD_DIV    clocks per bit (legal 8..4095)
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   RX          serial line, idle high, asynchronous to clk
//   batt_v      last received battery voltage
//   avg_curr    last received average current
//   avg_torque  last received average torque
//   pkt_rdy     one-cycle pulse when a complete packet is latched
//   frm_err     one-cycle pulse on a bad stop bit
// ============================================================================
module telemetry_rx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic [11:0] batt_v,
  output logic [11:0] avg_curr,
  output logic [11:0] avg_torque,
  output logic        pkt_rdy,
  output logic        frm_err
);

  // The counter expires on the cycle it reads zero, so a load of N gives an
  // interval of N+1 cycles. Loading one less keeps bit spacing at exactly
  // BAUD_DIV and avoids drift across the nine sample points of a frame.
  localparam logic [11:0] HALF_LOAD = 12'(BAUD_DIV / 2 - 1);
  localparam logic [11:0] BIT_LOAD  = 12'(BAUD_DIV - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [1:0] SYNC1   = 2'd0;
  localparam logic [1:0] SYNC2   = 2'd1;
  localparam logic [1:0] PAYLOAD = 2'd2;

  // --------------------------------------------------------------------------
  // Synchronizer and edge detect (all flops idle high)
  // --------------------------------------------------------------------------
  logic rx_meta, rx_sync, rx_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // --------------------------------------------------------------------------
  // Bit-level FSM
  // --------------------------------------------------------------------------
  logic [1:0]  bit_state;
  logic [11:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        expire;
  logic        byte_rdy;
  logic        stop_bad;

  assign expire   = (baud_cnt == 12'd0);
  // Stop-bit verdicts are combinational so the packet FSM can act on them in
  // the sample cycle, putting pkt_rdy/frm_err on the following cycle.
  assign byte_rdy = (bit_state == STOP) && expire &&  rx_sync;
  assign stop_bad = (bit_state == STOP) && expire && !rx_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_state <= IDLE;
      baud_cnt  <= 12'd0;
      bit_idx   <= 3'd0;
      shift     <= 8'd0;
      frm_err   <= 1'b0;
    end else begin
      frm_err <= stop_bad;
      case (bit_state)
        IDLE: begin
          if (rx_prev && !rx_sync) begin
            bit_state <= START;
            baud_cnt  <= HALF_LOAD;
          end
        end
        START: begin
          if (expire) begin
            if (!rx_sync) begin
              bit_state <= DATA;
              baud_cnt  <= BIT_LOAD;
              bit_idx   <= 3'd0;
            end else begin
              // Line went back high by mid-start-bit: treat as a glitch.
              bit_state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 12'd1;
          end
        end
        DATA: begin
          if (expire) begin
            shift    <= {rx_sync, shift[7:1]};
            baud_cnt <= BIT_LOAD;
            if (bit_idx == 3'd7) begin
              bit_state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - 12'd1;
          end
        end
        default: begin // STOP
          if (expire) begin
            bit_state <= IDLE;
          end else begin
            baud_cnt <= baud_cnt - 12'd1;
          end
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Packet FSM
  // --------------------------------------------------------------------------
  logic [1:0] pkt_state;
  logic [2:0] byte_idx;
  logic [3:0] batt_hi, curr_hi, torque_hi;
  logic [7:0] batt_lo, curr_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_state  <= SYNC1;
      byte_idx   <= 3'd0;
      batt_hi    <= 4'd0;
      batt_lo    <= 8'd0;
      curr_hi    <= 4'd0;
      curr_lo    <= 8'd0;
      torque_hi  <= 4'd0;
      batt_v     <= 12'd0;
      avg_curr   <= 12'd0;
      avg_torque <= 12'd0;
      pkt_rdy    <= 1'b0;
    end else begin
      pkt_rdy <= 1'b0;
      if (stop_bad) begin
        // Abandon any partial packet; staging is overwritten next time.
        pkt_state <= SYNC1;
      end else if (byte_rdy) begin
        case (pkt_state)
          SYNC1: begin
            if (shift == 8'hAA) pkt_state <= SYNC2;
          end
          SYNC2: begin
            if (shift == 8'h55) begin
              pkt_state <= PAYLOAD;
              byte_idx  <= 3'd0;
            end else if (shift != 8'hAA) begin
              pkt_state <= SYNC1;
            end
          end
          default: begin // PAYLOAD: sync values here are plain data
            byte_idx <= byte_idx + 3'd1;
            case (byte_idx)
              3'd0: batt_hi   <= shift[3:0];
              3'd1: batt_lo   <= shift;
              3'd2: curr_hi   <= shift[3:0];
              3'd3: curr_lo   <= shift;
              3'd4: torque_hi <= shift[3:0];
              default: begin
                batt_v     <= {batt_hi, batt_lo};
                avg_curr   <= {curr_hi, curr_lo};
                avg_torque <= {torque_hi, shift};
                pkt_rdy    <= 1'b1;
                pkt_state  <= SYNC1;
              end
            endcase
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_telemetry_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_telemetry_rx
// Description : Directed self-checking bench for telemetry_rx (BAUD_DIV=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_telemetry_rx;

  localparam int BD = 16;

  logic        clk;
  logic        rst_n;
  logic        RX;
  logic [11:0] batt_v, avg_curr, avg_torque;
  logic        pkt_rdy, frm_err;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int pkt_cnt = 0;
  int err_cnt = 0;
  logic [11:0] cap_b = 12'd0;

  telemetry_rx #(.BAUD_DIV(BD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RX         (RX),
    .batt_v     (batt_v),
    .avg_curr   (avg_curr),
    .avg_torque (avg_torque),
    .pkt_rdy    (pkt_rdy),
    .frm_err    (frm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge; a pulse longer than one
  // cycle is counted more than once.
  always @(negedge clk) begin
    if (pkt_rdy) begin
      pkt_cnt = pkt_cnt + 1;
      cap_b   = batt_v;
    end
    if (frm_err) err_cnt = err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      fails = fails + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bits(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    RX = 1'b0;
    bits(BD);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      bits(BD);
    end
    RX = stop_ok;
    bits(BD);
    RX = 1'b1;
  endtask

  task automatic send_pkt(input logic [63:0] p);
    for (int i = 7; i >= 0; i--) send_byte(p[i*8 +: 8], 1'b1);
  endtask

  task automatic chk_out(input string tag, input logic [11:0] b,
                         input logic [11:0] c, input logic [11:0] t);
    chk({tag, "_batt"},   {20'd0, batt_v},     {20'd0, b});
    chk({tag, "_curr"},   {20'd0, avg_curr},   {20'd0, c});
    chk({tag, "_torque"}, {20'd0, avg_torque}, {20'd0, t});
  endtask

  initial begin
    rst_n = 1'b0;
    RX    = 1'b1;
    bits(4);
    chk_out("reset", 12'h000, 12'h000, 12'h000);
    chk("reset_pkt_rdy", {31'd0, pkt_rdy}, 32'd0);
    chk("reset_frm_err", {31'd0, frm_err}, 32'd0);
    rst_n = 1'b1;
    bits(2 * BD);

    // Basic back-to-back packet.
    send_pkt(64'hAA55_0A98_0123_07FF);
    bits(4);
    chk("t1_pkt_cnt", pkt_cnt, 1);
    chk_out("t1", 12'hA98, 12'h123, 12'h7FF);
    chk("t1_cap_at_rdy", {20'd0, cap_b}, 32'h0A98);
    chk("t1_no_frm_err", err_cnt, 0);

    // Leading junk and double 0xAA resync; upper nibble of high byte dropped.
    send_byte(8'h13, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_pkt(64'hAA55_F100_0000_0002);
    bits(4);
    chk("t2_pkt_cnt", pkt_cnt, 2);
    chk_out("t2", 12'h100, 12'h000, 12'h002);

    // Framing error mid-packet abandons it; outputs hold.
    send_byte(8'hAA, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h0A, 1'b1);
    send_byte(8'h98, 1'b1);
    send_byte(8'h11, 1'b0);
    bits(2 * BD);
    chk("t3_err_cnt", err_cnt, 1);
    chk("t3_pkt_cnt_hold", pkt_cnt, 2);
    chk_out("t3_hold", 12'h100, 12'h000, 12'h002);
    send_pkt(64'hAA55_0555_0011_0022);
    bits(4);
    chk("t3_pkt_cnt", pkt_cnt, 3);
    chk_out("t3", 12'h555, 12'h011, 12'h022);

    // Short low glitch while idle is rejected as a false start.
    RX = 1'b0;
    bits(BD / 4);
    RX = 1'b1;
    bits(3 * BD);
    chk("t4_err_cnt", err_cnt, 1);
    chk("t4_pkt_cnt_hold", pkt_cnt, 3);
    send_pkt(64'hAA55_0102_0304_0506);
    bits(4);
    chk("t4_pkt_cnt", pkt_cnt, 4);
    chk_out("t4", 12'h102, 12'h304, 12'h506);

    // Sync values inside the payload are plain data.
    send_pkt(64'hAA55_0AAA_0055_0FFF);
    bits(4);
    chk("t5_pkt_cnt", pkt_cnt, 5);
    chk_out("t5", 12'hAAA, 12'h055, 12'hFFF);

    // Reset in the middle of payload byte 3.
    send_byte(8'hAA, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    RX = 1'b0;
    bits(BD);
    RX = 1'b1;
    bits(3 * BD);
    #1 rst_n = 1'b0;
    #1;
    chk_out("t6_rst", 12'h000, 12'h000, 12'h000);
    chk("t6_rst_pkt_rdy", {31'd0, pkt_rdy}, 32'd0);
    RX = 1'b1;
    bits(3);
    rst_n = 1'b1;
    bits(2 * BD);
    chk("t6_pkt_cnt_hold", pkt_cnt, 5);
    send_pkt(64'hAA55_0C34_0567_089A);
    bits(4);
    chk("t6_pkt_cnt", pkt_cnt, 6);
    chk_out("t6", 12'hC34, 12'h567, 12'h89A);
    chk("final_err_cnt", err_cnt, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/telemetry_rx.md
# telemetry_rx

Receive-side counterpart of the eBike telemetry transmitter. Deserializes the 8N1 UART stream on RX, frames the 8-byte telemetry packet (0xAA, 0x55, then battery voltage, average current and average torque as high/low byte pairs), and presents the three 12-bit values with a one-cycle packet-ready strobe. Used in the test harness and the display/logging side to recover what the drive unit reports.

## Interface
- BAUD_DIV, 2604, clocks per bit (50 MHz / 19200 baud); legal range 8..4095
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- RX  input  1  serial line, idle high, asynchronous to clk
- batt_v  output  12  last received battery voltage
- avg_curr  output  12  last received average current
- avg_torque  output  12  last received average torque
- pkt_rdy  output  1  one-cycle pulse when a complete packet is latched
- frm_err  output  1  one-cycle pulse on bad stop bit

## Operation
- RX passes through a 2-flop synchronizer, preset to 1 on reset; all logic uses the synchronized value.
- Bit-level FSM, states IDLE, START, DATA, STOP:
  - IDLE: synchronized RX falling edge (previous 1, current 0) -> START, baud counter loaded with BAUD_DIV/2 (integer divide).
  - START: at counter expiry, RX still 0 -> DATA, counter BAUD_DIV, bit index 0; RX 1 -> false start, back to IDLE, nothing reported.
  - DATA: sample RX at each counter expiry into shift register LSB first; after 8th sample -> STOP, counter BAUD_DIV.
  - STOP: at expiry, RX 1 -> byte valid (internal byte_rdy one cycle), RX 0 -> frm_err pulse, byte discarded. Either way -> IDLE same cycle; a new falling edge can be accepted the next cycle.
- Packet FSM, states SYNC1, SYNC2, PAYLOAD, advances only on byte_rdy:
  - SYNC1: byte 0xAA -> SYNC2; otherwise stay.
  - SYNC2: 0x55 -> PAYLOAD, byte index 0; 0xAA -> stay in SYNC2; other -> SYNC1.
  - PAYLOAD: bytes 0..5 written to staging registers in order batt_hi, batt_lo, curr_hi, curr_lo, torque_hi, torque_lo. High bytes use bits [3:0] only; bits [7:4] ignored. After byte 5 -> outputs updated together from staging, pkt_rdy pulsed, -> SYNC1.
- Payload byte values 0xAA/0x55 are data, never re-sync, while in PAYLOAD.
- frm_err in any packet state: packet abandoned, staging discarded, packet FSM -> SYNC1; outputs keep previous values.
- Outputs change only on pkt_rdy; never partially updated.

## Timing
- Reset: batt_v, avg_curr, avg_torque = 0; pkt_rdy, frm_err = 0; bit FSM IDLE; packet FSM SYNC1; synchronizer flops 1.
- Synchronizer adds 2 clk latency from RX pin to internal edge detect.
- Data bit n sampled at (n+1)*BAUD_DIV + BAUD_DIV/2 clk (±1) after the synchronized falling edge; stop bit at 9*BAUD_DIV + BAUD_DIV/2.
- pkt_rdy and new output values appear the cycle after the stop-bit sample of payload byte 5; outputs valid in the same cycle pkt_rdy is high.
- frm_err is high the cycle after the offending stop-bit sample.
- Baud counter 12 bits, counts down; expiry at 0.
- Back-to-back frames with no idle time between stop and next start are received without loss.
- rst_n asserted mid-byte or mid-packet: everything returns to reset values immediately; partially received packet lost; outputs cleared.

## Test plan
- BAUD_DIV=16; send AA 55 0A 98 01 23 07 FF back-to-back -> single pkt_rdy pulse, batt_v=0xA98, avg_curr=0x123, avg_torque=0x7FF; no frm_err.
- Send 13 AA AA 55 F1 00 00 00 00 02 -> leading junk ignored, double 0xAA resyncs; pkt_rdy with batt_v=0x100, avg_curr=0x000, avg_torque=0x002 (upper nibble F dropped).
- Send AA 55 0A 98 then byte with stop bit 0, then full valid packet (batt 0x555) -> one frm_err pulse, outputs unchanged until second packet, then batt_v=0x555.
- RX low glitch of BAUD_DIV/4 clocks while IDLE -> no byte, no frm_err, subsequent packet decoded correctly.
- Payload containing AA 55 (AA 55 0A AA 00 55 0F FF) -> batt_v=0xAAA, avg_curr=0x055, avg_torque=0xFFF.
- Assert rst_n low during payload byte 3 -> all outputs 0 immediately; next full packet decoded normally.
